// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded fields, forwards from
// EX/MEM and MEM/WB, builds AluOp/X/Y, and stalls ID for one cycle on load-use.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [3:0]    id_aluop,
    input  logic [RW-1:0] id_rs_num,
    input  logic [RW-1:0] id_rt_num,
    input  logic [RW-1:0] id_rd_num,
    input  logic [DW-1:0] id_rs_val,
    input  logic [DW-1:0] id_rt_val,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [1:0]    id_ysel,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_regwrite,
    input  logic          flush,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic          stall,
    output logic          ex_valid,
    output logic [3:0]    AluOp,
    output logic [DW-1:0] X,
    output logic [DW-1:0] Y,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_rd,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_regwrite
);

    typedef enum logic [1:0] {
        YSEL_RT     = 2'd0,
        YSEL_IMM    = 2'd1,
        YSEL_SHAMT  = 2'd2,
        YSEL_VARSHF = 2'd3
    } ysel_e;

    typedef struct packed {
        logic          valid;
        logic [3:0]    aluop;
        logic [RW-1:0] rs_num;
        logic [RW-1:0] rt_num;
        logic [RW-1:0] rd_num;
        logic [DW-1:0] rs_val;
        logic [DW-1:0] rt_val;
        logic [DW-1:0] imm;
        logic [4:0]    shamt;
        ysel_e         ysel;
        logic          memread;
        logic          memwrite;
        logic          regwrite;
    } ex_fields_t;

    ex_fields_t ex_d, ex_q;

    logic [DW-1:0] fwd_rs, fwd_rt;
    logic          hit_rs, hit_rt;

    // Youngest producer wins; register 0 never forwards so it reads as regfile zero.
    function automatic logic [DW-1:0] forward(input logic [RW-1:0] num,
                                              input logic [DW-1:0] reg_val);
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == num))
            return exmem_result;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == num))
            return memwb_data;
        else
            return reg_val;
    endfunction

    // Load-use: the load in EX has no data until MEM, so ID must wait one cycle.
    always_comb begin
        hit_rs = id_uses_rs && (id_rs_num == ex_q.rd_num);
        hit_rt = id_uses_rt && (id_rt_num == ex_q.rd_num);
        stall  = ex_q.valid && ex_q.memread && (ex_q.rd_num != '0) && !flush
                 && (hit_rs || hit_rt);
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ex_d = '0;
        if (!(flush || stall)) begin
            ex_d.valid    = id_valid;
            ex_d.aluop    = id_aluop;
            ex_d.rs_num   = id_rs_num;
            ex_d.rt_num   = id_rt_num;
            ex_d.rd_num   = id_rd_num;
            ex_d.rs_val   = id_rs_val;
            ex_d.rt_val   = id_rt_val;
            ex_d.imm      = id_imm;
            ex_d.shamt    = id_shamt;
            ex_d.ysel     = ysel_e'(id_ysel);
            ex_d.memread  = id_valid && id_memread;
            ex_d.memwrite = id_valid && id_memwrite;
            ex_d.regwrite = id_valid && id_regwrite;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset here is synchronous.
        if (!rst_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    always_comb begin
        fwd_rs = forward(ex_q.rs_num, ex_q.rs_val);
        fwd_rt = forward(ex_q.rt_num, ex_q.rt_val);
        X = fwd_rs;
        Y = fwd_rt;
        unique case (ex_q.ysel)
            YSEL_RT:     begin X = fwd_rs; Y = fwd_rt;                           end
            YSEL_IMM:    begin X = fwd_rs; Y = ex_q.imm;                         end
            YSEL_SHAMT:  begin X = fwd_rt; Y = {{(DW-5){1'b0}}, ex_q.shamt};     end
            YSEL_VARSHF: begin X = fwd_rt; Y = fwd_rs;                           end
            default:     begin X = fwd_rs; Y = fwd_rt;                           end
        endcase
    end

    assign ex_store_data = fwd_rt;
    assign ex_valid      = ex_q.valid;
    assign AluOp         = ex_q.aluop;
    assign ex_rd         = ex_q.rd_num;
    assign ex_memread    = ex_q.memread;
    assign ex_memwrite   = ex_q.memwrite;
    assign ex_regwrite   = ex_q.regwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a stage-level model predicts each EX cycle,
// a negedge monitor compares the DUT against the queued predictions.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [3:0]    id_aluop;
    logic [RW-1:0] id_rs_num, id_rt_num, id_rd_num;
    logic [DW-1:0] id_rs_val, id_rt_val, id_imm;
    logic [4:0]    id_shamt;
    logic          id_uses_rs, id_uses_rt;
    logic [1:0]    id_ysel;
    logic          id_memread, id_memwrite, id_regwrite;
    logic          flush;
    logic          exmem_regwrite;
    logic [RW-1:0] exmem_rd;
    logic [DW-1:0] exmem_result;
    logic          memwb_regwrite;
    logic [RW-1:0] memwb_rd;
    logic [DW-1:0] memwb_data;
    logic          stall, ex_valid;
    logic [3:0]    AluOp;
    logic [DW-1:0] X, Y, ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          ex_memread, ex_memwrite, ex_regwrite;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_aluop(id_aluop),
        .id_rs_num(id_rs_num), .id_rt_num(id_rt_num), .id_rd_num(id_rd_num),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_ysel(id_ysel), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_regwrite(id_regwrite), .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .stall(stall), .ex_valid(ex_valid), .AluOp(AluOp), .X(X), .Y(Y),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus: ID instruction, flush/reset, and the forwarding
    // sources visible to whatever instruction EX holds during that cycle.
    typedef struct {
        bit          rst_n;
        bit          valid;
        logic [3:0]  aluop;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsv, rtv, imm;
        logic [4:0]  shamt;
        bit          urs, urt;
        logic [1:0]  ysel;
        bit          mr, mw, rw;
        bit          flush;
        bit          xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        bit          ww;
        logic [4:0]  wrd;
        logic [31:0] wdata;
    } stim_t;

    typedef struct {
        bit          stall, valid, mr, mw, rw;
        logic [3:0]  aluop;
        logic [31:0] x, y, sd;
        logic [4:0]  rd;
    } exp_t;

    exp_t  sb[$];
    stim_t m_ex;        // instruction the model believes EX holds
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] value_of(input logic [4:0] num, input logic [31:0] regval,
                                             input stim_t c);
        if (num != 0 && c.xw && c.xrd == num) return c.xres;
        if (num != 0 && c.ww && c.wrd == num) return c.wdata;
        return regval;
    endfunction

    // Drive one cycle, predict what EX shows during it, then advance the model.
    task automatic step(input stim_t s);
        exp_t        e;
        logic [31:0] a, b;
        @(posedge clk); #1;
        rst_n = s.rst_n; id_valid = s.valid; id_aluop = s.aluop;
        id_rs_num = s.rs; id_rt_num = s.rt; id_rd_num = s.rd;
        id_rs_val = s.rsv; id_rt_val = s.rtv; id_imm = s.imm; id_shamt = s.shamt;
        id_uses_rs = s.urs; id_uses_rt = s.urt; id_ysel = s.ysel;
        id_memread = s.mr; id_memwrite = s.mw; id_regwrite = s.rw; flush = s.flush;
        exmem_regwrite = s.xw; exmem_rd = s.xrd; exmem_result = s.xres;
        memwb_regwrite = s.ww; memwb_rd = s.wrd; memwb_data = s.wdata;

        a = value_of(m_ex.rs, m_ex.rsv, s);
        b = value_of(m_ex.rt, m_ex.rtv, s);
        e.stall = m_ex.valid && m_ex.mr && m_ex.rd != 0 && !s.flush &&
                  ((s.urs && s.rs == m_ex.rd) || (s.urt && s.rt == m_ex.rd));
        e.valid = m_ex.valid; e.mr = m_ex.mr; e.mw = m_ex.mw; e.rw = m_ex.rw;
        e.aluop = m_ex.aluop; e.rd = m_ex.rd; e.sd = b;
        case (m_ex.ysel)
            2'd0:    begin e.x = a; e.y = b;                  end
            2'd1:    begin e.x = a; e.y = m_ex.imm;           end
            2'd2:    begin e.x = b; e.y = {27'b0, m_ex.shamt}; end
            default: begin e.x = b; e.y = a;                  end
        endcase
        sb.push_back(e);

        if (!s.rst_n || s.flush || e.stall) begin
            m_ex = '{default: 0};
        end else begin
            m_ex = s;
            if (!s.valid) begin m_ex.mr = 0; m_ex.mw = 0; m_ex.rw = 0; end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("stall",         32'(stall),       32'(e.stall));
            check("ex_valid",      32'(ex_valid),    32'(e.valid));
            check("AluOp",         32'(AluOp),       32'(e.aluop));
            check("X",             X,                e.x);
            check("Y",             Y,                e.y);
            check("ex_store_data", ex_store_data,    e.sd);
            check("ex_rd",         32'(ex_rd),       32'(e.rd));
            check("ex_memread",    32'(ex_memread),  32'(e.mr));
            check("ex_memwrite",   32'(ex_memwrite), 32'(e.mw));
            check("ex_regwrite",   32'(ex_regwrite), 32'(e.rw));
        end
    end

    initial begin
        stim_t s, held;
        bit    prev_stall;
        m_ex = '{default: 0};
        s = idle();
        rst_n = 1'b0; id_valid = 1'b1; id_aluop = 4'd7;
        id_rs_num = '0; id_rt_num = '0; id_rd_num = 5'd3;
        id_rs_val = '0; id_rt_val = '0; id_imm = '0; id_shamt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_ysel = '0;
        id_memread = 1'b0; id_memwrite = 1'b0; id_regwrite = 1'b1; flush = 1'b0;
        exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_regwrite = 1'b0; memwb_rd = '0; memwb_data = '0;

        // Reset held two cycles with a valid instruction presented.
        s.rst_n = 0; s.valid = 1; s.aluop = 4'd7; s.rd = 5'd3; s.rw = 1; s.rsv = 32'h55;
        step(s);
        step(s);

        // Plain add, no forwarding.
        s = idle(); s.valid = 1; s.aluop = 4'd5; s.rs = 5'd3; s.rsv = 32'd5;
        s.rt = 5'd4; s.rtv = 32'd7; s.rd = 5'd10; s.rw = 1; s.urs = 1; s.urt = 1;
        step(s);

        // Forward priority on rs=8, then MEM/WB only, then register 0.
        s = idle(); s.valid = 1; s.aluop = 4'd1; s.rs = 5'd8; s.rsv = 32'h99;
        s.rt = 5'd2; s.rtv = 32'h3; s.rd = 5'd11; s.rw = 1; s.urs = 1;
        step(s);
        s.xw = 1; s.xrd = 5'd8; s.xres = 32'h11; s.ww = 1; s.wrd = 5'd8; s.wdata = 32'h22;
        step(s);
        s = idle(); s.valid = 1; s.aluop = 4'd2; s.rs = 5'd0; s.rsv = 32'h0; s.rd = 5'd12;
        s.rw = 1; s.ww = 1; s.wrd = 5'd8; s.wdata = 32'h22;
        step(s);
        s = idle(); s.xw = 1; s.xrd = 5'd0; s.xres = 32'hdead; s.ww = 1; s.wrd = 5'd0;
        s.wdata = 32'hbeef;
        step(s);

        // Load-use: stall once, bubble, then stall drops.
        s = idle(); s.valid = 1; s.aluop = 4'd0; s.rs = 5'd2; s.rsv = 32'h100; s.imm = 32'h4;
        s.ysel = 2'd1; s.rd = 5'd9; s.mr = 1; s.rw = 1; s.urs = 1;
        step(s);
        held = idle(); held.valid = 1; held.aluop = 4'd5; held.rs = 5'd9; held.rsv = 32'h7;
        held.rt = 5'd1; held.rtv = 32'h1; held.rd = 5'd13; held.rw = 1; held.urs = 1; held.urt = 1;
        step(held);
        step(held);
        step(s);
        held.flush = 1;
        step(held);

        // Constant and variable shifts.
        s = idle(); s.valid = 1; s.aluop = 4'd8; s.rt = 5'd5; s.rtv = 32'h80000001;
        s.shamt = 5'd4; s.ysel = 2'd2; s.rd = 5'd14; s.rw = 1; s.urt = 1;
        step(s);
        s = idle(); s.valid = 1; s.aluop = 4'd9; s.rs = 5'd6; s.rsv = 32'h25;
        s.rt = 5'd7; s.rtv = 32'h1234; s.ysel = 2'd3; s.rd = 5'd15; s.rw = 1; s.urs = 1; s.urt = 1;
        step(s);

        // Flushed store must not reach EX.
        s = idle(); s.valid = 1; s.aluop = 4'd0; s.rs = 5'd1; s.rsv = 32'h40; s.rt = 5'd2;
        s.rtv = 32'h77; s.imm = 32'h8; s.ysel = 2'd1; s.mw = 1; s.urs = 1; s.urt = 1; s.flush = 1;
        step(s);
        step(idle());

        // Randomized traffic over a small register set so hazards are frequent.
        prev_stall = 0;
        held = idle();
        for (int i = 0; i < 600; i++) begin
            if (prev_stall) begin
                s = held;
            end else begin
                s = idle();
                s.valid = ($urandom_range(0, 9) != 0);
                s.aluop = 4'($urandom);
                s.rs    = 5'($urandom_range(0, 7));
                s.rt    = 5'($urandom_range(0, 7));
                s.rd    = 5'($urandom_range(0, 7));
                s.rsv   = (s.rs == 0) ? 32'h0 : $urandom;
                s.rtv   = (s.rt == 0) ? 32'h0 : $urandom;
                s.imm   = $urandom;
                s.shamt = 5'($urandom);
                s.urs   = 1'($urandom);
                s.urt   = 1'($urandom);
                s.ysel  = 2'($urandom);
                s.mr    = ($urandom_range(0, 3) == 0);
                s.mw    = !s.mr && ($urandom_range(0, 4) == 0);
                s.rw    = !s.mw && 1'($urandom);
            end
            s.rst_n = ($urandom_range(0, 40) != 0);
            s.flush = ($urandom_range(0, 9) == 0);
            s.xw    = 1'($urandom);
            s.xrd   = 5'($urandom_range(0, 7));
            s.xres  = $urandom;
            s.ww    = 1'($urandom);
            s.wrd   = 5'($urandom_range(0, 7));
            s.wdata = $urandom;
            step(s);
            prev_stall = sb[$].stall;
            held = s;
        end

        step(idle());
        @(negedge clk); #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage that directly feeds the ALU.
- Registers decoded control and operand data from ID.
- Resolves data hazards by forwarding from EX/MEM and MEM/WB.
- Builds the ALU inputs AluOp, X and Y, plus store data and memory/writeback controls for the next stage.
- Detects load-use hazards, requests an ID stall, and inserts a bubble into EX.

Parameters:
DW, 32, datapath width
RW, 5, register-number width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_aluop  in  4  ALU opcode for EX
id_rs_num  in  RW  source register rs
id_rt_num  in  RW  source register rt
id_rd_num  in  RW  destination register (already muxed rt/rd/31 by decode)
id_rs_val  in  DW  regfile read of rs
id_rt_val  in  DW  regfile read of rt
id_imm  in  DW  extended immediate
id_shamt  in  5  shift amount field
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_ysel  in  2  0: Y=rt, 1: Y=imm, 2: const shift, 3: variable shift
id_memread  in  1  load
id_memwrite  in  1  store
id_regwrite  in  1  writes register file
flush  in  1  squash the ID instruction (branch/jump taken)
exmem_regwrite  in  1  EX/MEM writes a register
exmem_rd  in  RW  EX/MEM destination
exmem_result  in  DW  EX/MEM ALU result
memwb_regwrite  in  1  MEM/WB writes a register
memwb_rd  in  RW  MEM/WB destination
memwb_data  in  DW  MEM/WB writeback data
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
AluOp  out  4  to ALU
X  out  DW  ALU operand X
Y  out  DW  ALU operand Y
ex_store_data  out  DW  forwarded rt for stores
ex_rd  out  RW  destination register
ex_memread  out  1  load in EX
ex_memwrite  out  1  store in EX
ex_regwrite  out  1  writes register in EX

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-low on rst_n.
- Reset state: all registered fields 0. Resulting outputs: ex_valid=0, AluOp=0, ex_rd=0, all control outputs 0.
- Registered update, highest priority first:
  - rst_n=0: clear all fields.
  - flush=1 or stall=1: load a bubble (valid and all controls 0, AluOp=0, data fields 0).
  - Otherwise: capture all id_* fields. When id_valid=0, control fields are captured as 0.
- Latency: exactly 1 cycle from ID inputs to EX outputs. There is no enable beyond stall/flush.
- Load-use stall (combinational, from registered state):
  - stall = ex_valid & ex_memread & ex_rd!=0 & ~flush & ((id_uses_rs & id_rs_num==ex_rd) | (id_uses_rt & id_rt_num==ex_rd)).
  - One stall cycle per load-use. On the next cycle EX holds a bubble, so stall drops.
- Forwarding (combinational, separately for registered rs and rt; value fwd_rs / fwd_rt):
  - Use exmem_result if exmem_regwrite & exmem_rd!=0 & exmem_rd==num.
  - Else use memwb_data if memwb_regwrite & memwb_rd!=0 & memwb_rd==num.
  - Else use the registered regfile value.
  - EX/MEM has priority over MEM/WB. Register 0 always yields the registered value, which is 0 by regfile.
- Operand build, by ysel:
  - 0: X=fwd_rs, Y=fwd_rt.
  - 1: X=fwd_rs, Y=imm.
  - 2: X=fwd_rt, Y={27'b0, shamt}.
  - 3: X=fwd_rt, Y=fwd_rs. The ALU uses only Y[4:0].
- ex_store_data = fwd_rt regardless of ysel.
- Bubble outputs: AluOp=0, X=Y=0, all controls 0. No architectural effect.
- Simultaneous flush and stall-condition: flush wins, stall=0, bubble loaded.
- Reset mid-stall: stall=0 on the cycle after reset asserts, because ex_memread is cleared.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 → ex_valid=0, AluOp=0, X=Y=0, stall=0. Release → next instruction appears 1 cycle later.
- Plain add: rs=3 (val 5), rt=4 (val 7), aluop=5, ysel=0, no forwarding matches → next cycle AluOp=5, X=5, Y=7, ex_rd as given.
- Forward priority: rs=8 with exmem_rd=8 result 0x11, memwb_rd=8 data 0x22 → X=0x11. Drop exmem_regwrite → X=0x22. Set rs=0 with both rd=0 → X=registered 0.
- Load-use: EX holds lw with rd=9, ID reads rs=9 with uses_rs=1 → stall=1 for one cycle, EX becomes a bubble, then stall=0. Flush during the same cycle → stall=0.
- Shifts: ysel=2, rt val 0x80000001, shamt=4 → X=0x80000001, Y=4. ysel=3, rs val 0x25 → Y=0x25.
- Flush: flush=1 with a valid store in ID → next cycle ex_valid=0, ex_memwrite=0, ex_regwrite=0.
